// File: rtl/cl_divider.sv
// cl_divider
//   Sequential carry-less (GF(2)) polynomial divider. Divides a 2m-bit
//   polynomial by a monic degree-m divisor, producing one quotient bit per
//   clock, and returns the quotient and the remainder.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; busy=0
//   DIV   | one long-division step per edge, count runs m..1
//   DONE  | done=1 for a single cycle, results valid, then back to IDLE
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle request, accepted only while busy=0
//   in_width     field degree m (legal 2..DATA_WIDTH)
//   dividend_in  dividend polynomial (bits at and above 2m ignored)
//   divisor_in   divisor polynomial (bit m must be set, bits above m ignored)
//   busy         operation in progress (DIV or DONE)
//   done         one-cycle completion pulse
//   err          last operation had illegal in_width or divisor_in[m]=0
//   quotient     quotient, zero-extended above bit m-1
//   remainder    remainder, zero-extended above bit m-1
module cl_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(DATA_WIDTH):0]   in_width,
  input  logic [2*DATA_WIDTH-1:0]       dividend_in,
  input  logic [DATA_WIDTH:0]           divisor_in,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         quotient,
  output logic [DATA_WIDTH-1:0]         remainder
);

  localparam int N  = DATA_WIDTH;
  localparam int WW = $clog2(N) + 1;
  localparam logic [WW-1:0] N_W = WW'(N);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state;
  logic [2*N-1:0]  w_q;
  logic [N:0]      d_q;
  logic [N-1:0]    q_q;
  logic [WW-1:0]   count_q;
  logic [WW-1:0]   m_q;

  // Operand normalization: both operands are left-aligned so that the
  // divisor's x^m term lines up with W[2N-1] regardless of m.
  logic            msb_set;
  logic            legal;
  logic [WW-1:0]   sh_d;
  logic [WW:0]     sh_w;
  logic [2*N-1:0]  w_norm;
  logic [N:0]      d_norm;

  always_comb begin
    msb_set = 1'b0;
    if (in_width <= N_W) msb_set = divisor_in[in_width];
    legal  = (in_width >= WW'(2)) && (in_width <= N_W) && msb_set;
    sh_d   = N_W - in_width;
    sh_w   = {sh_d, 1'b0};
    // {2N ones} >> 2(N-m) is exactly a 2m-bit mask; likewise for the divisor.
    w_norm = (dividend_in & ({(2*N){1'b1}} >> sh_w)) << sh_w;
    d_norm = (divisor_in & ({(N+1){1'b1}} >> sh_d)) << sh_d;
  end

  // One long-division step.
  logic            qbit;
  logic [2*N-1:0]  w_x;
  logic [2*N-1:0]  w_next;
  logic [N-1:0]    q_next;
  logic [N-1:0]    r_top;
  logic [N-1:0]    r_next;

  always_comb begin
    qbit = w_q[2*N-1];
    w_x  = w_q;
    if (qbit) w_x[2*N-1 -: N+1] = w_q[2*N-1 -: N+1] ^ d_q;
    w_next = w_x << 1;
    q_next = {q_q[N-2:0], qbit};
    // Remainder sits in the top m bits of the upper half after m shifts.
    r_top  = w_next[2*N-1 -: N];
    r_next = r_top >> (N_W - m_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_q       <= '0;
      d_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      m_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (legal) begin
              w_q     <= w_norm;
              d_q     <= d_norm;
              q_q     <= '0;
              count_q <= in_width;
              m_q     <= in_width;
              state   <= DIV;
            end else begin
              err       <= 1'b1;
              quotient  <= '0;
              remainder <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DIV: begin
          w_q     <= w_next;
          q_q     <= q_next;
          count_q <= count_q - WW'(1);
          if (count_q == WW'(1)) begin
            quotient  <= q_next;
            remainder <= r_next;
            err       <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
